// File: rtl/fss_pkg.sv
// Shared types for the fault shutdown sequencer.
// FSS_SOFT_START_EN selects the RAMP_UP soft-start path.
package fss_pkg;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_RAMP_DOWN = 3'd1,
    ST_HOLD      = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_RAMP_UP   = 3'd4,
    ST_LOCKOUT   = 3'd5
  } state_t;

  localparam int CAUSE_WDT = 0;
  localparam int CAUSE_EXT = 1;

  function automatic int amp_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/amp_ramp.sv
// Saturating carrier amplitude ramp register.
// at_min/at_max flag that the next step lands on the limit.
module amp_ramp
  import fss_pkg::*;
#(
  parameter int AMP_W     = 12,
  parameter int RAMP_STEP = 256
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             up,
  input  logic             down,
  input  logic             load_zero,
  input  logic             load_max,
  output logic [AMP_W-1:0] level,
  output logic             at_min,
  output logic             at_max
);

  localparam logic [AMP_W:0] STEP_W = (AMP_W+1)'(RAMP_STEP);
  localparam logic [AMP_W:0] MAX_W  = (AMP_W+1)'(amp_max(AMP_W));

  logic [AMP_W:0] dn;
  logic [AMP_W:0] upv;

  assign dn     = {1'b0, level} - STEP_W;
  assign upv    = {1'b0, level} + STEP_W;
  assign at_min = dn[AMP_W] | (dn == '0);
  assign at_max = upv >= MAX_W;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level <= '0;
    end else if (load_zero) begin
      level <= '0;
    end else if (load_max) begin
      level <= MAX_W[AMP_W-1:0];
    end else if (down) begin
      level <= dn[AMP_W] ? '0 : dn[AMP_W-1:0];
    end else if (up) begin
      level <= at_max ? MAX_W[AMP_W-1:0] : upv[AMP_W-1:0];
    end
  end

endmodule

// File: rtl/fault_shutdown_sequencer.sv
// Fault-driven carrier ramp-down, subsystem reset and lockout.
// FSS_SOFT_START_EN enables the RAMP_UP soft-start state.
module fault_shutdown_sequencer
  import fss_pkg::*;
#(
  parameter int AMP_W         = 12,
  parameter int RAMP_STEP     = 256,
  parameter int HOLD_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int MAX_FAULTS    = 3,
  parameter int FCNT_W        = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              force_reset,
  input  logic              ext_fault,
  input  logic              clear_lockout,
  output logic [AMP_W-1:0]  amp_scale,
  output logic              rf_enable,
  output logic              sys_rstn,
  output logic [2:0]        state_o,
  output logic [FCNT_W-1:0] fault_count,
  output logic [1:0]        last_cause,
  output logic              lockout
);

  localparam int CNT_MAX =
    (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [FCNT_W-1:0] FCNT_SAT   = '1;
  localparam logic [FCNT_W:0] LOCK_AT      = (FCNT_W+1)'(MAX_FAULTS);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             lock_pend;
  logic             trig;
  logic             up, down, ld_zero, ld_max;
  logic             hit, clr;
  logic             rf_n, srst_n, lock_n;
  logic             at_min;
  logic [FCNT_W-1:0] fcnt_inc;
`ifdef FSS_SOFT_START_EN
  logic             at_max;
`endif

  assign trig     = force_reset | ext_fault;
  assign state_o  = state;
  assign fcnt_inc = (fault_count == FCNT_SAT) ?
                    fault_count : fault_count + 1'b1;

  amp_ramp #(
    .AMP_W     (AMP_W),
    .RAMP_STEP (RAMP_STEP)
  ) u_ramp (
    .clk       (clk),
    .rstn      (rstn),
    .up        (up),
    .down      (down),
    .load_zero (ld_zero),
    .load_max  (ld_max),
    .level     (amp_scale),
    .at_min    (at_min),
`ifdef FSS_SOFT_START_EN
    .at_max    (at_max)
`else
    .at_max    ()
`endif
  );

  always_comb begin
    state_n = state;
    cnt_n   = '0;
    up      = 1'b0;
    down    = 1'b0;
    ld_zero = 1'b0;
    ld_max  = 1'b0;
    hit     = 1'b0;
    clr     = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (trig) begin
          hit     = 1'b1;
          state_n = ST_RAMP_DOWN;
        end
      end
`ifdef FSS_SOFT_START_EN
      ST_RAMP_UP: begin
        if (trig) begin
          hit     = 1'b1;
          state_n = ST_RAMP_DOWN;
        end else begin
          up = 1'b1;
          if (at_max) state_n = ST_RUN;
        end
      end
`endif
      ST_RAMP_DOWN: begin
        down = 1'b1;
        if (at_min) state_n = ST_HOLD;
      end
      ST_HOLD: begin
        ld_zero = 1'b1;
        if (cnt == HOLD_LAST)
          state_n = lock_pend ? ST_LOCKOUT : ST_SETTLE;
        else
          cnt_n = cnt + 1'b1;
      end
      ST_SETTLE: begin
        // counter parks at its last value while trig holds us here
        if (cnt == SETTLE_LAST && !trig) begin
`ifdef FSS_SOFT_START_EN
          state_n = ST_RAMP_UP;
`else
          state_n = ST_RUN;
          ld_max  = 1'b1;
`endif
        end else if (cnt != SETTLE_LAST) begin
          cnt_n = cnt + 1'b1;
        end else begin
          cnt_n = cnt;
        end
      end
      ST_LOCKOUT: begin
        ld_zero = 1'b1;
        if (clear_lockout) begin
          clr     = 1'b1;
          state_n = ST_SETTLE;
        end
      end
      default: state_n = ST_HOLD;
    endcase
    rf_n   = state_n inside {ST_RUN, ST_RAMP_DOWN, ST_RAMP_UP};
    srst_n = state_n inside {ST_RUN, ST_RAMP_DOWN,
                             ST_SETTLE, ST_RAMP_UP};
    lock_n = state_n == ST_LOCKOUT;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_HOLD;
      cnt         <= '0;
      rf_enable   <= 1'b0;
      sys_rstn    <= 1'b0;
      lockout     <= 1'b0;
      fault_count <= '0;
      last_cause  <= '0;
      lock_pend   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rf_enable <= rf_n;
      sys_rstn  <= srst_n;
      lockout   <= lock_n;
      if (clr) begin
        fault_count <= '0;
        lock_pend   <= 1'b0;
      end else if (hit) begin
        fault_count           <= fcnt_inc;
        last_cause[CAUSE_WDT] <= force_reset;
        last_cause[CAUSE_EXT] <= ext_fault;
        if ({1'b0, fcnt_inc} >= LOCK_AT) lock_pend <= 1'b1;
      end
    end
  end

endmodule
